// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: drives a req/gnt/rvalid data-memory port from the
// ALU effective address, builds store lanes/byte enables and extends load data.
module lsu_mem_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [ADDR_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  rd_valid,
    output logic                  lsu_fault,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [3:0]            r_mem_be;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic                  r_rd_valid;
    logic [1:0]            r_addr_lo;
    logic [2:0]            r_funct3;

    logic                  w_req;
    logic                  w_legal;
    logic                  w_aligned;
    logic                  w_idle;
    logic                  w_start;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_ext;

    always_comb begin
        w_legal = 1'b0;
        case (Funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
            default:                                w_legal = 1'b0;
        endcase
        w_aligned = 1'b1;
        case (Funct3[1:0])
            2'b01:   w_aligned = ~ALUResult[0];
            2'b10:   w_aligned = (ALUResult[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
    end

    // Gating with reset keeps every output at 0 while reset is held, even with a live request.
    assign w_req     = MemRead | MemWrite;
    assign w_idle    = (r_state == S_IDLE) && reset;
    assign w_start   = w_idle && w_req && w_legal && w_aligned;
    assign lsu_fault = w_idle && w_req && !(w_legal && w_aligned);
    assign stall     = w_start || (r_state == S_REQ) || (r_state == S_WAIT);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = WriteData;
        case (Funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << ALUResult[1:0];
                w_wdata = {4{WriteData[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {ALUResult[1], 1'b0};
                w_wdata = {2{WriteData[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = WriteData;
            end
        endcase
    end

    always_comb begin
        w_byte = mem_rdata[7:0];
        case (r_addr_lo)
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            2'd3:    w_byte = mem_rdata[31:24];
            default: w_byte = mem_rdata[7:0];
        endcase
        w_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        // Funct3[2] selects zero extension (BU/HU).
        case (r_funct3[1:0])
            2'b00:   w_ext = {{24{~r_funct3[2] & w_byte[7]}}, w_byte};
            2'b01:   w_ext = {{16{~r_funct3[2] & w_half[15]}}, w_half};
            default: w_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_read_data <= '0;
            r_rd_valid  <= 1'b0;
            r_addr_lo   <= '0;
            r_funct3    <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state     <= S_REQ;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= ~MemRead;
                        r_mem_addr  <= {ALUResult[ADDR_WIDTH-1:2], 2'b00};
                        r_mem_be    <= w_be;
                        r_mem_wdata <= w_wdata;
                        r_addr_lo   <= ALUResult[1:0];
                        r_funct3    <= Funct3;
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= r_mem_we ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        r_read_data <= w_ext;
                        r_rd_valid  <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;
    assign ReadData  = r_read_data;
    assign rd_valid  = r_rd_valid;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: inputs change on the falling edge, outputs are
// sampled 1ns later, and the memory side is played by the bench.
module tb_lsu_mem_stage;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        stall;
    logic [31:0] ReadData;
    logic        rd_valid;
    logic        lsu_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    lsu_mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData),
        .stall(stall), .ReadData(ReadData), .rd_valid(rd_valid), .lsu_fault(lsu_fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic go_idle();
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
    endtask

    // Drives one access and plays memory: gnt after gw wait cycles, rvalid in the first WAIT cycle.
    // Returns at the retiring (DONE) cycle so a following access can start in the next cycle.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                          input int gw, output logic [31:0] rdout, output logic rdv,
                          output int ncyc, output int nreq, output logic stall0,
                          output logic [3:0] be_s, output logic [31:0] wd_s,
                          output logic we_s, output logic ok);
        int w;
        logic granted, gave;
        w = gw; granted = 1'b0; gave = 1'b0; ok = 1'b0; ncyc = 0; nreq = 0;
        rdout = '0; rdv = 1'b0; be_s = '0; wd_s = '0; we_s = 1'b0; stall0 = 1'b0;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = a; WriteData = wd;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (c == 0) stall0 = stall;
            if (gave) granted = 1'b1;
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (granted && !stall) begin
                ok = 1'b1; rdout = ReadData; rdv = rd_valid; ncyc = c;
                break;
            end
            if (mem_req) begin
                if (nreq == 0) begin be_s = mem_be; wd_s = mem_wdata; we_s = mem_we; end
                nreq++;
                if (w == 0) begin mem_gnt = 1'b1; gave = 1'b1; end
                else w--;
            end else if (granted && stall) begin
                mem_rvalid = 1'b1; mem_rdata = rdat;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010;
        ALUResult = 32'h100; WriteData = '0; mem_gnt = 1'b1; mem_rvalid = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        #3;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL reset_readdata got %h exp 0", ReadData); end
        checks++; if ({rd_valid, lsu_fault, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
            errors++; $display("FAIL reset_outputs got rv=%b f=%b we=%b be=%b a=%h wd=%h exp all 0",
                               rd_valid, lsu_fault, mem_we, mem_be, mem_addr, mem_wdata);
        end
        @(negedge clk);
        MemRead = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++; if ({stall, mem_req, rd_valid} !== 3'b000) begin
            errors++; $display("FAIL post_reset_idle got stall/req/rv=%b exp 000", {stall, mem_req, rd_valid});
        end
    endtask

    task automatic test_lw_min_latency();
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h100;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        checks++; if ({stall, mem_req} !== 2'b10) begin errors++; $display("FAIL lw_T stall/req got %b exp 10", {stall, mem_req}); end
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        checks++; if ({stall, mem_req, mem_we} !== 3'b110) begin errors++; $display("FAIL lw_T1 stall/req/we got %b exp 110", {stall, mem_req, mem_we}); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL lw_addr got %h exp 00000100", mem_addr); end
        checks++; if (mem_be !== 4'b1111) begin errors++; $display("FAIL lw_be got %b exp 1111", mem_be); end
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if ({stall, mem_req, rd_valid} !== 3'b100) begin errors++; $display("FAIL lw_T2 stall/req/rv got %b exp 100", {stall, mem_req, rd_valid}); end
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        checks++; if ({stall, rd_valid} !== 2'b01) begin errors++; $display("FAIL lw_T3 stall/rv got %b exp 01", {stall, rd_valid}); end
        checks++; if (ReadData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", ReadData); end
        go_idle();
        checks++; if ({stall, rd_valid, mem_req} !== 3'b000) begin errors++; $display("FAIL lw_after got %b exp 000", {stall, rd_valid, mem_req}); end
    endtask

    task automatic test_load_extend();
        logic [31:0] rdout, wd_s;
        logic rdv, stall0, we_s, ok;
        logic [3:0] be_s;
        int ncyc, nreq;
        access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, rdout, rdv, ncyc, nreq, stall0, be_s, wd_s, we_s, ok);
        checks++; if ({ok, rdv} !== 2'b11) begin errors++; $display("FAIL lb_done got ok/rv=%b exp 11", {ok, rdv}); end
        checks++; if (rdout !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h exp ffffff80", rdout); end
        checks++; if (be_s !== 4'b1000) begin errors++; $display("FAIL lb_be got %b exp 1000", be_s); end
        access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1, rdout, rdv, ncyc, nreq, stall0, be_s, wd_s, we_s, ok);
        checks++; if (rdout !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data got %h exp 00000080", rdout); end
        checks++; if (ncyc !== 4) begin errors++; $display("FAIL lbu_latency got %0d exp 4", ncyc); end
        access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_0000, 0, rdout, rdv, ncyc, nreq, stall0, be_s, wd_s, we_s, ok);
        checks++; if (rdout !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_data got %h exp ffff80ff", rdout); end
        checks++; if (be_s !== 4'b1100) begin errors++; $display("FAIL lh_be got %b exp 1100", be_s); end
        access(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'hFFFF_8001, 0, rdout, rdv, ncyc, nreq, stall0, be_s, wd_s, we_s, ok);
        checks++; if (rdout !== 32'h0000_8001) begin errors++; $display("FAIL lhu_data got %h exp 00008001", rdout); end
        checks++; if (be_s !== 4'b0011) begin errors++; $display("FAIL lhu_be got %b exp 0011", be_s); end
        go_idle();
    endtask

    task automatic test_sh_wait_states();
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b1; Funct3 = 3'b001; ALUResult = 32'h102;
        WriteData = 32'h1234_ABCD; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sh_start_stall got %b exp 1", stall); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_gnt = (i == 3);
            #1;
            checks++;
            if ({stall, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {3'b111, 4'b1100, 32'h100, 32'hABCD_ABCD}) begin
                errors++;
                $display("FAIL sh_req_cycle%0d got stall=%b req=%b we=%b be=%b a=%h wd=%h exp 1 1 1 1100 00000100 abcdabcd",
                         i, stall, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
            end
        end
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        checks++; if ({stall, mem_req, rd_valid} !== 3'b000) begin errors++; $display("FAIL sh_done got stall/req/rv=%b exp 000", {stall, mem_req, rd_valid}); end
        go_idle();
        checks++; if ({stall, mem_req} !== 2'b00) begin errors++; $display("FAIL sh_after got %b exp 00", {stall, mem_req}); end
    endtask

    task automatic test_faults();
        logic [31:0] addrs [3];
        logic [2:0]  f3s   [3];
        addrs[0] = 32'h101; f3s[0] = 3'b010;
        addrs[1] = 32'h003; f3s[1] = 3'b001;
        addrs[2] = 32'h100; f3s[2] = 3'b011;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            MemRead = 1'b1; MemWrite = 1'b0; Funct3 = f3s[i]; ALUResult = addrs[i];
            #1;
            checks++;
            if ({lsu_fault, stall, mem_req} !== 3'b100) begin
                errors++; $display("FAIL fault%0d fault/stall/req got %b exp 100", i, {lsu_fault, stall, mem_req});
            end
            go_idle();
            checks++;
            if ({lsu_fault, mem_req, rd_valid} !== 3'b000 || ReadData !== 32'h0000_8001) begin
                errors++; $display("FAIL fault%0d_after fault/req/rv=%b rd=%h exp 000 00008001",
                                   i, {lsu_fault, mem_req, rd_valid}, ReadData);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h200;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        checks++; if ({stall, mem_req} !== 2'b10) begin errors++; $display("FAIL rst_wait_state got stall/req=%b exp 10", {stall, mem_req}); end
        #1;
        reset = 1'b0; MemRead = 1'b0;
        #1;
        checks++; if ({stall, mem_req, rd_valid, lsu_fault} !== 4'b0000 || ReadData !== 32'h0) begin
            errors++; $display("FAIL rst_wait_outputs stall/req/rv/f=%b rd=%h exp 0000 0", {stall, mem_req, rd_valid, lsu_fault}, ReadData);
        end
        checks++; if ({mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
            errors++; $display("FAIL rst_wait_fields we=%b be=%b a=%h wd=%h exp 0", mem_we, mem_be, mem_addr, mem_wdata);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h55AA_55AA;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stale_stall got %b exp 0", stall); end
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        checks++; if ({rd_valid, mem_req, stall} !== 3'b000 || ReadData !== 32'h0) begin
            errors++; $display("FAIL rst_stale_rvalid rv/req/stall=%b rd=%h exp 000 0", {rd_valid, mem_req, stall}, ReadData);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rdout, wd_s;
        logic rdv, stall0, we_s, ok;
        logic [3:0] be_s;
        int ncyc, nreq;
        access(1'b0, 1'b1, 3'b010, 32'h40, 32'hCAFE_F00D, 32'h0, 0, rdout, rdv, ncyc, nreq, stall0, be_s, wd_s, we_s, ok);
        checks++; if ({ok, ncyc, nreq} !== {1'b1, 32'd2, 32'd1}) begin errors++; $display("FAIL b2b_sw ok=%b cyc=%0d req=%0d exp 1 2 1", ok, ncyc, nreq); end
        checks++; if ({we_s, be_s, wd_s, rdv} !== {1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0}) begin
            errors++; $display("FAIL b2b_sw_fields we=%b be=%b wd=%h rv=%b exp 1 1111 cafef00d 0", we_s, be_s, wd_s, rdv);
        end
        access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h1122_3344, 0, rdout, rdv, ncyc, nreq, stall0, be_s, wd_s, we_s, ok);
        checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL b2b_lw_start got stall=%b exp 1", stall0); end
        checks++; if ({ok, ncyc, nreq} !== {1'b1, 32'd3, 32'd1}) begin errors++; $display("FAIL b2b_lw ok=%b cyc=%0d req=%0d exp 1 3 1", ok, ncyc, nreq); end
        checks++; if ({rdv, we_s, rdout} !== {1'b1, 1'b0, 32'h1122_3344}) begin
            errors++; $display("FAIL b2b_lw_data rv=%b we=%b rd=%h exp 1 0 11223344", rdv, we_s, rdout);
        end
        go_idle();
        checks++; if ({mem_req, stall} !== 2'b00) begin errors++; $display("FAIL b2b_after req/stall=%b exp 00", {mem_req, stall}); end
    endtask

    initial begin
        test_reset();
        test_lw_min_latency();
        test_load_extend();
        test_sh_wait_states();
        test_faults();
        test_reset_in_wait();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
